// File: rtl/split_check_sequencer.sv
// rtl/split_check_sequencer.sv - sequences split-constraint checks for one candidate
//
// Walks one candidate assignment through NUM_SPLITS split blocks on a shared
// evaluator port, one split at a time, stopping at the first unsatisfied split
// or when the evaluator stays silent for TIMEOUT WAIT cycles.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   start_valid/ready     candidate handshake (ready only while idle)
//   abort                 synchronous cancel, highest priority
//   sel_valid, sel_idx    one-cycle issue pulse and index of the split under test
//   res_valid, res_x      evaluator result strobe and satisfaction bit
//   done_valid/ready      verdict handshake
//   done_pass, fail_idx,  verdict: all satisfied / first failing index /
//   timeout               failure caused by evaluator silence
module split_check_sequencer #(
  parameter int NUM_SPLITS = 16,
  parameter int IDX_W      = 4,
  parameter int TIMEOUT    = 15,
  parameter int TO_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             abort,
  output logic             sel_valid,
  output logic [IDX_W-1:0] sel_idx,
  input  logic             res_valid,
  input  logic             res_x,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             done_pass,
  output logic [IDX_W-1:0] fail_idx,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPLITS - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [TO_W-1:0]  to_cnt;
  logic             at_last;
  logic             expired;

  assign at_last = (idx == LAST_IDX);
  // Expiry is judged on the count of silent WAIT cycles already spent, so the
  // evaluator gets exactly TIMEOUT WAIT cycles to answer.
  assign expired = (to_cnt == TO_MAX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides every other event.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            state_nxt = ISSUE;
          end
        end
        ISSUE: begin
          state_nxt = WAIT;
        end
        WAIT: begin
          // A result arriving on the expiry cycle takes precedence.
          if (res_valid) begin
            if (!res_x || at_last) begin
              state_nxt = DONE;
            end else begin
              state_nxt = ISSUE;
            end
          end else if (expired) begin
            state_nxt = DONE;
          end
        end
        DONE: begin
          if (done_ready) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Output decode.
  always_comb begin
    start_ready = (state == IDLE);
    sel_valid   = (state == ISSUE);
    done_valid  = (state == DONE);
    sel_idx     = idx;
  end

  // Datapath: split index, timeout counter and the registered verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      to_cnt    <= '0;
      done_pass <= 1'b0;
      fail_idx  <= '0;
      timeout   <= 1'b0;
    end else if (abort) begin
      done_pass <= 1'b0;
      fail_idx  <= '0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            idx <= '0;
          end
        end
        ISSUE: begin
          to_cnt <= '0;
        end
        WAIT: begin
          if (res_valid) begin
            if (!res_x) begin
              done_pass <= 1'b0;
              fail_idx  <= idx;
              timeout   <= 1'b0;
            end else if (at_last) begin
              done_pass <= 1'b1;
              fail_idx  <= '0;
              timeout   <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end else if (expired) begin
            // Counter holds here rather than wrapping.
            done_pass <= 1'b0;
            fail_idx  <= idx;
            timeout   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        DONE: begin
          if (done_ready) begin
            done_pass <= 1'b0;
            fail_idx  <= '0;
            timeout   <= 1'b0;
          end
        end
        default: begin
          idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_split_check_sequencer.sv
// tb/tb_split_check_sequencer.sv - self-checking bench for split_check_sequencer
module tb_split_check_sequencer;

  localparam int N  = 16;
  localparam int IW = 4;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_valid = 1'b0;
  logic          abort = 1'b0;
  logic          done_ready = 1'b0;
  logic          start_ready;
  logic          sel_valid;
  logic [IW-1:0] sel_idx;
  logic          res_valid;
  logic          res_x;
  logic          done_valid;
  logic          done_pass;
  logic [IW-1:0] fail_idx;
  logic          timeout;

  logic ev_res_valid = 1'b0;
  logic ev_res_x = 1'b0;
  logic man_res_valid = 1'b0;
  logic man_res_x = 1'b0;
  logic eval_en = 1'b1;

  assign res_valid = eval_en ? ev_res_valid : man_res_valid;
  assign res_x     = eval_en ? ev_res_x : man_res_x;

  split_check_sequencer #(
    .NUM_SPLITS(N),
    .IDX_W(IW),
    .TIMEOUT(TO),
    .TO_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .abort(abort),
    .sel_valid(sel_valid),
    .sel_idx(sel_idx),
    .res_valid(res_valid),
    .res_x(res_x),
    .done_valid(done_valid),
    .done_ready(done_ready),
    .done_pass(done_pass),
    .fail_idx(fail_idx),
    .timeout(timeout)
  );

  initial forever #5 clk = ~clk;

  // Candidate script (evaluator behaviour) plus hand-computed expected verdict.
  // Cycle counts are from the acceptance cycle to the first done_valid cycle.
  typedef struct {
    int fail_at;
    int silent_at;
    int lat_idx;
    int lat_val;
    int hold;
    int exp_pass;
    int exp_fidx;
    int exp_to;
    int exp_cycles;
    int exp_issues;
  } vec_t;

  vec_t vecs[10];
  vec_t script_q[$];
  vec_t exp_q[$];
  vec_t cur;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Evaluator and verdict consumer, driven just after each rising edge.
  bit pend = 1'b0;
  int pidx = 0;
  int delay = 0;
  int hcnt = 0;

  initial begin
    cur = '{-1, -1, -1, 1, 0, 0, 0, 0, 0, 0};
    forever begin
      @(posedge clk);
      #1;
      ev_res_valid = 1'b0;
      if (!rst_n || abort) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          delay--;
          if (delay == 0) begin
            ev_res_valid = 1'b1;
            ev_res_x     = (pidx != cur.fail_at);
            pend         = 1'b0;
          end
        end
        if (sel_valid) begin
          pidx = int'(sel_idx);
          if (pidx != cur.silent_at) begin
            pend  = 1'b1;
            delay = (pidx == cur.lat_idx) ? cur.lat_val : 1;
          end
        end
      end
      if (done_valid) begin
        done_ready = (hcnt >= cur.hold);
        hcnt++;
      end else begin
        done_ready = 1'b0;
        hcnt = 0;
      end
    end
  end

  // Monitor / scoreboard, sampled on the falling edge.
  int cyc = 0;
  int base_cyc = 0;
  int exp_next = 0;
  int issued = 0;
  int hs_cyc = 0;
  bit done_seen = 1'b0;
  bit in_flight = 1'b0;
  bit hs_valid = 1'b0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      in_flight = 1'b0;
      hs_valid  = 1'b0;
    end else begin
      if (sel_valid) begin
        chk("sel_idx", int'(sel_idx), exp_next);
        exp_next++;
        issued++;
      end
      if (!in_flight) begin
        chk("done_valid_when_idle", int'(done_valid), 0);
      end else if (done_valid) begin
        if (!done_seen) begin
          chk("done_latency", cyc - base_cyc, exp_q[0].exp_cycles);
          done_seen = 1'b1;
        end
        chk("done_pass", int'(done_pass), exp_q[0].exp_pass);
        chk("fail_idx", int'(fail_idx), exp_q[0].exp_fidx);
        chk("timeout", int'(timeout), exp_q[0].exp_to);
        chk("start_ready_in_done", int'(start_ready), 0);
        if (done_ready) begin
          chk("issue_count", issued, exp_q[0].exp_issues);
          void'(exp_q.pop_front());
          in_flight = 1'b0;
          hs_valid  = 1'b1;
          hs_cyc    = cyc;
        end
      end
      if (abort) begin
        if (in_flight) void'(exp_q.pop_front());
        in_flight = 1'b0;
        hs_valid  = 1'b0;
      end else if (start_valid && start_ready) begin
        if (hs_valid) chk("b2b_accept_gap", cyc - hs_cyc, 1);
        hs_valid = 1'b0;
        if (script_q.size() == 0) begin
          chk("unscripted_accept", int'(start_valid), 0);
        end else begin
          cur = script_q.pop_front();
          exp_q.push_back(cur);
          in_flight = 1'b1;
          base_cyc  = cyc;
          exp_next  = 0;
          issued    = 0;
          done_seen = 1'b0;
        end
      end else if (start_ready) begin
        hs_valid = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  int budget;

  initial begin
    //            fail silent lidx lval hold pass fidx to cyc iss
    vecs[0] = '{-1, -1, -1,  1, 10, 1,  0, 0, 33, 16};
    vecs[1] = '{ 5, -1, -1,  1,  0, 0,  5, 0, 13,  6};
    vecs[2] = '{-1,  3, -1,  1,  0, 0,  3, 1, 23,  4};
    vecs[3] = '{ 2, -1,  2, 15,  0, 0,  2, 0, 21,  3};
    vecs[4] = '{-1, -1,  2, 15,  0, 1,  0, 0, 47, 16};
    vecs[5] = '{ 0, -1, -1,  1,  0, 0,  0, 0,  3,  1};
    vecs[6] = '{15, -1, -1,  1,  0, 0, 15, 0, 33, 16};
    vecs[7] = '{-1, 15, -1,  1,  0, 0, 15, 1, 47, 16};
    vecs[8] = '{-1, -1,  9, 16,  0, 0,  9, 1, 35, 10};
    vecs[9] = '{-1, -1,  4,  3,  3, 1,  0, 0, 35, 16};

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start_ready", int'(start_ready), 1);
    chk("rst_sel_valid", int'(sel_valid), 0);
    chk("rst_sel_idx", int'(sel_idx), 0);
    chk("rst_done_valid", int'(done_valid), 0);
    chk("rst_done_pass", int'(done_pass), 0);
    chk("rst_fail_idx", int'(fail_idx), 0);
    chk("rst_timeout", int'(timeout), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table run with start_valid held high: back-to-back candidates.
    foreach (vecs[i]) script_q.push_back(vecs[i]);
    start_valid = 1'b1;
    budget = 3000;
    while (script_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    start_valid = 1'b0;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    chk("table_pending_scripts", script_q.size(), 0);
    chk("table_pending_verdicts", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;

    // Abort during the WAIT for split 7, then a stray result.
    script_q.push_back('{-1, 7, -1, 1, 0, 0, 7, 1, 0, 8});
    start_valid = 1'b1;
    budget = 50;
    while (!in_flight && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    start_valid = 1'b0;
    budget = 100;
    while (!(sel_valid && sel_idx == IW'(7)) && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    chk("abort_reached_split7", int'(sel_valid), 1);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_start_ready", int'(start_ready), 1);
    chk("abort_sel_valid", int'(sel_valid), 0);
    chk("abort_done_valid", int'(done_valid), 0);
    eval_en = 1'b0;
    man_res_valid = 1'b1;
    man_res_x = 1'b0;
    @(posedge clk);
    #1;
    man_res_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("stray_res_start_ready", int'(start_ready), 1);
    chk("stray_res_sel_valid", int'(sel_valid), 0);
    chk("stray_res_done_valid", int'(done_valid), 0);
    eval_en = 1'b1;

    // Asynchronous reset in the middle of a WAIT.
    script_q.push_back('{-1, 3, -1, 1, 0, 0, 3, 1, 23, 4});
    start_valid = 1'b1;
    budget = 50;
    while (!in_flight && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    start_valid = 1'b0;
    budget = 100;
    while (!(sel_valid && sel_idx == IW'(3)) && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    chk("reset_reached_split3", int'(sel_valid), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_start_ready", int'(start_ready), 1);
    chk("async_sel_valid", int'(sel_valid), 0);
    chk("async_sel_idx", int'(sel_idx), 0);
    chk("async_done_valid", int'(done_valid), 0);
    chk("async_done_pass", int'(done_pass), 0);
    chk("async_fail_idx", int'(fail_idx), 0);
    chk("async_timeout", int'(timeout), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_start_ready", int'(start_ready), 1);
    chk("post_reset_done_valid", int'(done_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
